// File: rtl/accel_mem_resp_if.sv
// Shared accelerator/host memory bus: accelerator port, host port and ownership select.
interface accel_mem_resp_if;
  logic        accel_ext_sel;
  logic        accel_mem_req;
  logic        accel_mem_we;
  logic [31:0] accel_addr;
  logic [31:0] accel_result;
  logic [31:0] accel_in_data;
  logic        host_req;
  logic        host_we;
  logic [31:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_gnt;
  logic [31:0] host_rdata;
  logic        host_rvalid;

  modport master (
    output accel_ext_sel, accel_mem_req, accel_mem_we, accel_addr, accel_result,
    input  accel_in_data,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rdata, host_rvalid
  );

  modport slave (
    input  accel_ext_sel, accel_mem_req, accel_mem_we, accel_addr, accel_result,
    output accel_in_data,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rdata, host_rvalid
  );
endinterface

// File: rtl/accel_mem_resp.sv
// Single-port word memory shared between an accelerator and a host, with
// one-cycle registered reads, sticky error flags and saturating access counters.
module accel_mem_resp #(
  parameter int unsigned DEPTH      = 512,
  parameter logic [31:0] RD_ERR_VAL = 32'hDEAD_BEEF
) (
  input  logic               clk,
  input  logic               rst,
  accel_mem_resp_if.slave    bus,
  input  logic               err_clr,
  output logic               err_addr,
  output logic               err_proto,
  output logic [15:0]        accel_rd_cnt,
  output logic [15:0]        accel_wr_cnt
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];

  logic          accel_acc;
  logic          acc_valid;
  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [AW-1:0] acc_idx;
  logic          in_range;
  logic [31:0]   rd_word;
  logic          addr_err;
  logic          proto_err;

  // Ownership makes host and accelerator accesses mutually exclusive,
  // so a single shared access path serves both ports.
  always_comb begin
    bus.host_gnt = bus.host_req & ~bus.accel_ext_sel;
    accel_acc    = bus.accel_mem_req & bus.accel_ext_sel;
    acc_valid    = accel_acc | bus.host_gnt;
    acc_we       = bus.accel_ext_sel ? bus.accel_mem_we : bus.host_we;
    acc_addr     = bus.accel_ext_sel ? bus.accel_addr   : bus.host_addr;
    acc_wdata    = bus.accel_ext_sel ? bus.accel_result : bus.host_wdata;
    acc_idx      = acc_addr[AW-1:0];
    in_range     = (acc_addr[31:AW] == '0);
    rd_word      = in_range ? mem[acc_idx] : RD_ERR_VAL;
    addr_err     = acc_valid & ~in_range;
    proto_err    = bus.accel_mem_req & ~bus.accel_ext_sel;
  end

  always_ff @(posedge clk) begin
    if (!rst && acc_valid && acc_we && in_range)
      mem[acc_idx] <= acc_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.accel_in_data <= '0;
      bus.host_rdata    <= '0;
      bus.host_rvalid   <= 1'b0;
    end else begin
      bus.host_rvalid <= bus.host_gnt & ~bus.host_we;
      if (accel_acc && !bus.accel_mem_we)
        bus.accel_in_data <= rd_word;
      if (bus.host_gnt && !bus.host_we)
        bus.host_rdata <= rd_word;
    end
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_addr  <= 1'b0;
      err_proto <= 1'b0;
    end else begin
      if (addr_err)     err_addr <= 1'b1;
      else if (err_clr) err_addr <= 1'b0;
      if (proto_err)    err_proto <= 1'b1;
      else if (err_clr) err_proto <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      accel_rd_cnt <= '0;
      accel_wr_cnt <= '0;
    end else if (accel_acc) begin
      if (bus.accel_mem_we) begin
        if (accel_wr_cnt != '1) accel_wr_cnt <= accel_wr_cnt + 16'd1;
      end else begin
        if (accel_rd_cnt != '1) accel_rd_cnt <= accel_rd_cnt + 16'd1;
      end
    end
  end
endmodule
